jtag_tap: RTL

- JTAG Test Access Port responder inside TachyonCPU.
- Sits at the far end of the pin interface driven by the SimDpiJtag bitbang driver and OpenOCD: consumes tck/tms/tdi/trst and drives tdo.
- Oversamples the slow TCK in the core `clk` domain and runs the IEEE 1149.1 16-state controller.
- Provides IR, BYPASS, IDCODE and one 32-bit USER data register with a capture/update handshake to the debug unit.

---
 rtl/jtag_tap.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/jtag_tap.sv
// JTAG TAP responder: oversamples TCK/TMS/TDI/TRST in the core clock domain,
// runs the 16-state TAP controller and provides IR, BYPASS, IDCODE and a
// USER data register with capture/update pulses towards the debug unit.
module jtag_tap #(
    parameter int                  IR_WIDTH   = 5,
    parameter logic [31:0]         IDCODE_VAL = 32'h1000_0DB3,
    parameter logic [IR_WIDTH-1:0] USER_IR    = 5'h10,
    parameter int                  USER_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  tck,
    input  logic                  tms,
    input  logic                  tdi,
    input  logic                  trst,
    output logic                  tdo,
    output logic                  tdo_en,
    output logic [IR_WIDTH-1:0]   ir,
    input  logic [USER_WIDTH-1:0] user_capture_data,
    output logic                  user_capture,
    output logic [USER_WIDTH-1:0] user_update_data,
    output logic                  user_update
);

    // Data register is wide enough for both IDCODE and USER contents.
    localparam int DR_WIDTH = (USER_WIDTH > 32) ? USER_WIDTH : 32;
    localparam logic [IR_WIDTH-1:0] IDCODE_IR = IR_WIDTH'(1);

    typedef enum logic [3:0] {
        TLR, RTI,
        SEL_DR, CAP_DR, SHIFT_DR, EXIT1_DR, PAUSE_DR, EXIT2_DR, UPD_DR,
        SEL_IR, CAP_IR, SHIFT_IR, EXIT1_IR, PAUSE_IR, EXIT2_IR, UPD_IR
    } tap_state_e;

    logic tck_s1_q, tck_s2_q, tck_s3_q;
    logic tms_s1_q, tms_s2_q;
    logic tdi_s1_q, tdi_s2_q;
    logic trst_s1_q, trst_s2_q;

    tap_state_e            state_q;
    tap_state_e            state_d;
    logic [IR_WIDTH-1:0]   ir_q;
    logic [IR_WIDTH-1:0]   ir_shift_q;
    logic [DR_WIDTH-1:0]   dr_q;
    logic [DR_WIDTH-1:0]   dr_shift_d;
    logic                  tdo_q;
    logic                  tdo_en_q;
    logic                  user_capture_q;
    logic                  user_update_q;
    logic [USER_WIDTH-1:0] user_update_data_q;

    logic tck_rise, tck_fall, tap_reset, bypass_sel;

    // TAP controller successor for the current TMS value.
    function automatic tap_state_e next_state(input tap_state_e s, input logic m);
        case (s)
            TLR:      return m ? TLR      : RTI;
            RTI:      return m ? SEL_DR   : RTI;
            SEL_DR:   return m ? SEL_IR   : CAP_DR;
            CAP_DR:   return m ? EXIT1_DR : SHIFT_DR;
            SHIFT_DR: return m ? EXIT1_DR : SHIFT_DR;
            EXIT1_DR: return m ? UPD_DR   : PAUSE_DR;
            PAUSE_DR: return m ? EXIT2_DR : PAUSE_DR;
            EXIT2_DR: return m ? UPD_DR   : SHIFT_DR;
            UPD_DR:   return m ? SEL_DR   : RTI;
            SEL_IR:   return m ? TLR      : CAP_IR;
            CAP_IR:   return m ? EXIT1_IR : SHIFT_IR;
            SHIFT_IR: return m ? EXIT1_IR : SHIFT_IR;
            EXIT1_IR: return m ? UPD_IR   : PAUSE_IR;
            PAUSE_IR: return m ? EXIT2_IR : PAUSE_IR;
            EXIT2_IR: return m ? UPD_IR   : SHIFT_IR;
            UPD_IR:   return m ? SEL_DR   : RTI;
            default:  return TLR;
        endcase
    endfunction

    // Two-flop synchronisers for all pins plus a third TCK stage for edge detection.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            tck_s1_q  <= 1'b0;
            tck_s2_q  <= 1'b0;
            tck_s3_q  <= 1'b0;
            tms_s1_q  <= 1'b0;
            tms_s2_q  <= 1'b0;
            tdi_s1_q  <= 1'b0;
            tdi_s2_q  <= 1'b0;
            trst_s1_q <= 1'b0;
            trst_s2_q <= 1'b0;
        end else begin
            tck_s1_q  <= tck;
            tck_s2_q  <= tck_s1_q;
            tck_s3_q  <= tck_s2_q;
            tms_s1_q  <= tms;
            tms_s2_q  <= tms_s1_q;
            tdi_s1_q  <= tdi;
            tdi_s2_q  <= tdi_s1_q;
            trst_s1_q <= trst;
            trst_s2_q <= trst_s1_q;
        end
    end

    assign tck_rise   = tck_s2_q & ~tck_s3_q;
    assign tck_fall   = ~tck_s2_q & tck_s3_q;
    // The synchronisers stay running under TRST so edge detection is clean on release.
    assign tap_reset  = ~rstn | trst_s2_q;
    assign bypass_sel = (ir_q != IDCODE_IR) && (ir_q != USER_IR);
    assign state_d    = next_state(state_q, tms_s2_q);

    // Shift-DR next value: one-bit BYPASS, or right shift into the MSB of the selected length.
    always_comb begin
        dr_shift_d = dr_q;
        if (bypass_sel) begin
            dr_shift_d[0] = tdi_s2_q;
        end else begin
            dr_shift_d = dr_q >> 1;
            if (ir_q == IDCODE_IR) dr_shift_d[31] = tdi_s2_q;
            else                   dr_shift_d[USER_WIDTH-1] = tdi_s2_q;
        end
    end

    // TAP controller, instruction/data registers, TDO launch and debug handshake pulses.
    always_ff @(posedge clk) begin
        if (tap_reset) begin
            state_q            <= TLR;
            ir_q               <= IDCODE_IR;
            ir_shift_q         <= '0;
            dr_q               <= '0;
            tdo_q              <= 1'b0;
            tdo_en_q           <= 1'b0;
            user_capture_q     <= 1'b0;
            user_update_q      <= 1'b0;
            user_update_data_q <= '0;
        end else begin
            user_capture_q <= 1'b0;
            user_update_q  <= 1'b0;
            if (tck_rise) begin
                case (state_q)
                    CAP_IR:   ir_shift_q <= IR_WIDTH'(1);
                    SHIFT_IR: ir_shift_q <= {tdi_s2_q, ir_shift_q[IR_WIDTH-1:1]};
                    UPD_IR:   ir_q <= ir_shift_q;
                    CAP_DR: begin
                        if (ir_q == IDCODE_IR) begin
                            dr_q <= DR_WIDTH'(IDCODE_VAL);
                        end else if (ir_q == USER_IR) begin
                            dr_q           <= DR_WIDTH'(user_capture_data);
                            user_capture_q <= 1'b1;
                        end else begin
                            dr_q[0] <= 1'b0;
                        end
                    end
                    SHIFT_DR: dr_q <= dr_shift_d;
                    UPD_DR: begin
                        if (ir_q == USER_IR) begin
                            user_update_data_q <= dr_q[USER_WIDTH-1:0];
                            user_update_q      <= 1'b1;
                        end
                    end
                    default: ;
                endcase
                state_q <= state_d;
                if (state_d == TLR) ir_q <= IDCODE_IR;
            end
            if (tck_fall) begin
                tdo_q    <= (state_q == SHIFT_IR) ? ir_shift_q[0] :
                            (state_q == SHIFT_DR) ? dr_q[0] : 1'b0;
                tdo_en_q <= (state_q == SHIFT_IR) || (state_q == SHIFT_DR);
            end
        end
    end

    assign tdo              = tdo_q;
    assign tdo_en           = tdo_en_q;
    assign ir               = ir_q;
    assign user_capture     = user_capture_q;
    assign user_update      = user_update_q;
    assign user_update_data = user_update_data_q;

endmodule
